// File: rtl/alu_multiply_sequencer_if.sv
// Port bundle of the multiply sequencer: host command/result, host ALU request and ALU port.
// The slave side is the sequencer; the master side is the CPU control unit plus the ALU.
interface alu_multiply_sequencer_if #(
  parameter int MUL_BITS = 16
);
  logic                start_i;
  logic [31:0]         op_a_i;
  logic [MUL_BITS-1:0] op_b_i;
  logic                busy_o;
  logic                done_o;
  logic [31:0]         product_o;
  logic                overflow_o;

  logic [31:0]         host_a_i;
  logic [31:0]         host_b_i;
  logic [4:0]          host_funsel_i;
  logic                host_wf_i;

  logic [31:0]         alu_a_o;
  logic [31:0]         alu_b_o;
  logic [4:0]          alu_funsel_o;
  logic                alu_wf_o;
  logic [31:0]         alu_out_i;

  modport slave (
    input  start_i, op_a_i, op_b_i,
    input  host_a_i, host_b_i, host_funsel_i, host_wf_i,
    input  alu_out_i,
    output busy_o, done_o, product_o, overflow_o,
    output alu_a_o, alu_b_o, alu_funsel_o, alu_wf_o
  );

  modport master (
    output start_i, op_a_i, op_b_i,
    output host_a_i, host_b_i, host_funsel_i, host_wf_i,
    output alu_out_i,
    input  busy_o, done_o, product_o, overflow_o,
    input  alu_a_o, alu_b_o, alu_funsel_o, alu_wf_o
  );
endinterface

// File: rtl/alu_multiply_sequencer.sv
// Shift-and-add 32-bit unsigned multiplier that borrows the shared ALU for its additions.
// Outside the STEP phase the host's ALU request is passed straight through.
module alu_multiply_sequencer #(
  parameter int         MUL_BITS   = 16,
  parameter logic [4:0] FUNSEL_ADD = 5'b10100
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  alu_multiply_sequencer_if.slave       bus
);
  localparam int CNT_W = (MUL_BITS > 1) ? $clog2(MUL_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         m_q, m_d;
  logic [MUL_BITS-1:0] q_q, q_d;
  logic [31:0]         p_q, p_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                lost_q, lost_d;
  logic                ovf_q, ovf_d;
  logic [31:0]         product_q, product_d;
  logic                overflow_q, overflow_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      q_q        <= '0;
      p_q        <= '0;
      cnt_q      <= '0;
      lost_q     <= 1'b0;
      ovf_q      <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      p_q        <= p_d;
      cnt_q      <= cnt_d;
      lost_q     <= lost_d;
      ovf_q      <= ovf_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  // Kept apart from the next-state logic so ALUOut (a function of these drives) never
  // appears to feed back into the process that produces them.
  always_comb begin
    bus.alu_a_o      = bus.host_a_i;
    bus.alu_b_o      = bus.host_b_i;
    bus.alu_funsel_o = bus.host_funsel_i;
    bus.alu_wf_o     = bus.host_wf_i;
    if (state_q == S_STEP) begin
      bus.alu_a_o      = p_q;
      bus.alu_b_o      = m_q;
      bus.alu_funsel_o = FUNSEL_ADD;
      bus.alu_wf_o     = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    p_d        = p_q;
    cnt_d      = cnt_q;
    lost_d     = lost_q;
    ovf_d      = ovf_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          m_d     = bus.op_a_i;
          q_d     = bus.op_b_i;
          p_d     = '0;
          cnt_d   = '0;
          lost_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        // An add with a truncated multiplicand or a wrapped sum means bits above 31 exist.
        if (q_q[0]) begin
          p_d = bus.alu_out_i;
          if ((bus.alu_out_i < p_q) || lost_q) begin
            ovf_d = 1'b1;
          end
        end
        m_d    = m_q << 1;
        lost_d = lost_q | m_q[31];
        q_d    = q_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d    = S_DONE;
          product_d  = p_d;
          overflow_d = ovf_d;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy_o     = (state_q == S_STEP);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.product_o  = product_q;
  assign bus.overflow_o = overflow_q;
endmodule

// File: tb/tb_alu_multiply_sequencer.sv
// Bench for alu_multiply_sequencer: scoreboard of 64-bit reference products checked on Done,
// plus per-scenario checks of latency, start filtering, reset abort and ALU port ownership.
module tb_alu_multiply_sequencer;
  localparam int MUL_BITS = 16;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic [31:0] product;
    logic        overflow;
  } exp_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  alu_multiply_sequencer_if #(.MUL_BITS(MUL_BITS)) bus ();

  alu_multiply_sequencer #(.MUL_BITS(MUL_BITS), .FUNSEL_ADD(5'b10100)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Combinational ALU: only the add function matters here.
  assign bus.alu_out_i = (bus.alu_funsel_o == 5'b10100) ? (bus.alu_a_o + bus.alu_b_o)
                                                          : 32'hDEAD_BEEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done_o) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got product=%h, required no Done pulse", bus.product_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("txn a=%h b=%h product=%h ovf=%0b (expected %h/%0b)",
                 e.a, e.b, bus.product_o, bus.overflow_o, e.product, e.overflow);
        if (bus.product_o !== e.product || bus.overflow_o !== e.overflow) begin
          errors++;
          $display("FAIL result: got product=%h ovf=%b, required product=%h ovf=%b",
                   bus.product_o, bus.overflow_o, e.product, e.overflow);
        end
      end
    end
  end

  // Must be called at posedge+#1 while the sequencer is idle.
  task automatic start_op(input logic [31:0] a, input logic [15:0] b);
    logic [63:0] full;
    exp_t        e;
    full       = {32'b0, a} * {48'b0, b};
    e.a        = a;
    e.b        = b;
    e.product  = full[31:0];
    e.overflow = |full[63:32];
    sb.push_back(e);
    bus.start_i = 1'b1;
    bus.op_a_i  = a;
    bus.op_b_i  = b;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.op_a_i  = $urandom;
    bus.op_b_i  = 16'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy=%b done=%b, required 0/0", bus.busy_o, bus.done_o);
    end
    checks++;
    if (bus.product_o !== 32'h0 || bus.overflow_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_result: got product=%h ovf=%b, required 0/0",
               bus.product_o, bus.overflow_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_basic;
    int busy_cnt = 0;
    int done_idx = -1;
    start_op(32'd7, 16'd6);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      if (bus.done_o && done_idx < 0) done_idx = k;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_cnt != MUL_BITS) begin
      errors++;
      $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, MUL_BITS);
    end
    checks++;
    if (done_idx != MUL_BITS) begin
      errors++;
      $display("FAIL done_latency: got sample %0d, required %0d", done_idx, MUL_BITS);
    end
  endtask

  task automatic test_boundaries;
    logic [31:0] a_tab [6] = '{32'hFFFF_FFFF, 32'h0001_0000, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [15:0] b_tab [6] = '{16'd1, 16'hFFFF, 16'd2, 16'd3, 16'hFFFF, 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      start_op(a_tab[i], b_tab[i]);
      idle_cycles(MUL_BITS + 2);
    end
    for (int i = 0; i < 4; i++) begin
      start_op($urandom, 16'($urandom));
      idle_cycles(MUL_BITS + 2);
    end
  endtask

  task automatic test_start_ignored;
    int done_idx = -1;
    start_op(32'd7, 16'd6);
    for (int k = 0; k < 22; k++) begin
      @(negedge clk);
      if (bus.done_o && done_idx < 0) done_idx = k;
      if (k == 18) begin
        checks++;
        if (bus.busy_o !== 1'b0) begin
          errors++;
          $display("FAIL start_in_done: got busy=%b, required 0", bus.busy_o);
        end
      end
      @(posedge clk);
      #1;
      bus.start_i = (k == 4) || (k == 15);
      if (k == 4) begin
        bus.op_a_i = 32'd100;
        bus.op_b_i = 16'd3;
      end
    end
    checks++;
    if (done_idx != MUL_BITS) begin
      errors++;
      $display("FAIL restart_latency: got sample %0d, required %0d", done_idx, MUL_BITS);
    end
  endtask

  task automatic test_reset_mid_step;
    exp_t dropped;
    bus.host_funsel_i = 5'b00011;
    start_op(32'd7, 16'd6);
    idle_cycles(8);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy_o !== 1'b0 || bus.product_o !== 32'h0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got busy=%b done=%b product=%h, required 0/0/0",
               bus.busy_o, bus.done_o, bus.product_o);
    end
    checks++;
    if (bus.alu_funsel_o !== 5'b00011) begin
      errors++;
      $display("FAIL reset_passthru: got funsel=%b, required 00011", bus.alu_funsel_o);
    end
    dropped = sb.pop_back();
    idle_cycles(2);
    rst_n = 1'b1;
    idle_cycles(MUL_BITS + 4);
  endtask

  task automatic test_passthrough;
    bus.host_a_i      = 32'h1234_5678;
    bus.host_b_i      = 32'h0BAD_F00D;
    bus.host_funsel_i = 5'b10110;
    bus.host_wf_i     = 1'b1;
    #1;
    checks++;
    if (bus.alu_a_o !== 32'h1234_5678 || bus.alu_b_o !== 32'h0BAD_F00D ||
        bus.alu_funsel_o !== 5'b10110 || bus.alu_wf_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_passthru: got a=%h b=%h fs=%b wf=%b, required host values",
               bus.alu_a_o, bus.alu_b_o, bus.alu_funsel_o, bus.alu_wf_o);
    end
    start_op(32'd3, 16'd5);
    @(negedge clk);
    checks++;
    if (bus.alu_funsel_o !== 5'b10100 || bus.alu_wf_o !== 1'b0 ||
        bus.alu_a_o !== 32'd0 || bus.alu_b_o !== 32'd3) begin
      errors++;
      $display("FAIL step_drive: got a=%h b=%h fs=%b wf=%b, required 0/3/10100/0",
               bus.alu_a_o, bus.alu_b_o, bus.alu_funsel_o, bus.alu_wf_o);
    end
    for (int k = 1; k < MUL_BITS + 1; k++) @(negedge clk);
    checks++;
    if (bus.done_o !== 1'b1 || bus.alu_funsel_o !== 5'b10110 || bus.alu_wf_o !== 1'b1) begin
      errors++;
      $display("FAIL done_passthru: got done=%b fs=%b wf=%b, required 1/10110/1",
               bus.done_o, bus.alu_funsel_o, bus.alu_wf_o);
    end
    idle_cycles(3);
  endtask

  task automatic test_back_to_back;
    int  guard = 0;
    logic held = 1'b1;
    start_op(32'd5, 16'd9);
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.done_o && guard < 40);
    @(posedge clk);
    #1;
    start_op(32'd11, 16'd13);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (bus.busy_o && bus.product_o !== 32'd45) held = 1'b0;
    end while (!bus.done_o && guard < 40);
    checks++;
    if (!held || !bus.done_o) begin
      errors++;
      $display("FAIL product_hold: got held=%b done=%b, required 1/1", held, bus.done_o);
    end
    idle_cycles(3);
  endtask

  initial begin
    bus.start_i       = 1'b0;
    bus.op_a_i        = '0;
    bus.op_b_i        = '0;
    bus.host_a_i      = 32'hA5A5_0001;
    bus.host_b_i      = 32'h5A5A_0002;
    bus.host_funsel_i = 5'b00001;
    bus.host_wf_i     = 1'b1;
    rst_n             = 1'b0;

    test_reset();
    test_basic();
    test_boundaries();
    test_start_ignored();
    test_reset_mid_step();
    test_passthrough();
    test_back_to_back();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_done: got %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
